// File: rtl/mux_tree_sel.sv
// 2:1, 4:1 and 8:1 selectors over one shared data set d0..d7.
// Define MUX_OUT_REG_EN to register y2/y4/y8 behind clk/rst_n/en; otherwise outputs are combinational.
module mux_tree_sel #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   input  logic [WIDTH-1:0] d4,
   input  logic [WIDTH-1:0] d5,
   input  logic [WIDTH-1:0] d6,
   input  logic [WIDTH-1:0] d7,
   input  logic             s0,
   input  logic             s1,
   input  logic             s2,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y4,
   output logic [WIDTH-1:0] y8
);

   logic [WIDTH-1:0] y2_n;
   logic [WIDTH-1:0] y4_n;
   logic [WIDTH-1:0] y8_n;

   // Unknown select codes fall through to the default arm so X reaches the output instead of d0.
   always_comb begin
      y2_n = '0;
      case (s0)
         1'b0:    y2_n = d0;
         1'b1:    y2_n = d1;
         default: y2_n = 'x;
      endcase
   end

   always_comb begin
      y4_n = '0;
      case ({s1, s0})
         2'd0:    y4_n = d0;
         2'd1:    y4_n = d1;
         2'd2:    y4_n = d2;
         2'd3:    y4_n = d3;
         default: y4_n = 'x;
      endcase
   end

   always_comb begin
      y8_n = '0;
      case ({s2, s1, s0})
         3'd0:    y8_n = d0;
         3'd1:    y8_n = d1;
         3'd2:    y8_n = d2;
         3'd3:    y8_n = d3;
         3'd4:    y8_n = d4;
         3'd5:    y8_n = d5;
         3'd6:    y8_n = d6;
         3'd7:    y8_n = d7;
         default: y8_n = 'x;
      endcase
   end

`ifdef MUX_OUT_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y2 <= '0;
         y4 <= '0;
         y8 <= '0;
      end else if (en) begin
         y2 <= y2_n;
         y4 <= y4_n;
         y8 <= y8_n;
      end
   end
`else
   // Control inputs exist only for port compatibility with the registered build.
   logic unused_ctl;
   assign unused_ctl = &{1'b0, clk, rst_n, en};

   assign y2 = y2_n;
   assign y4 = y4_n;
   assign y8 = y8_n;
`endif

endmodule

// File: tb/tb_mux_tree_sel.sv
// Scoreboard bench for mux_tree_sel: WIDTH=1 and WIDTH=8 instances share selects and controls.
// Covers both the combinational build and the MUX_OUT_REG_EN registered build.
module tb_mux_tree_sel;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       s0, s1, s2;
   logic [7:0] dv;
   logic       y2, y4, y8;
   logic [7:0] w2, w4, w8;

   always #10 clk = ~clk;

   mux_tree_sel #(.WIDTH(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
      .d4(dv[4]), .d5(dv[5]), .d6(dv[6]), .d7(dv[7]),
      .s0(s0), .s1(s1), .s2(s2),
      .y2(y2), .y4(y4), .y8(y8)
   );

   mux_tree_sel #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en),
      .d0(8'hA0), .d1(8'hA1), .d2(8'hA2), .d3(8'hA3),
      .d4(8'hA4), .d5(8'hA5), .d6(8'hA6), .d7(8'hA7),
      .s0(s0), .s1(s1), .s2(s2),
      .y2(w2), .y4(w4), .y8(w8)
   );

   typedef struct {
      string      name;
      logic       y2, y4, y8;
      bit         chk_w;
      logic [7:0] w2, w4, w8;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   event sample_now;

   task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", name, got, want);
      end
   endtask

   // Entries are popped one per negedge (registered/combinational results) or per immediate trigger.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or sample_now);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.name, ".y2"}, {7'd0, y2}, {7'd0, e.y2});
            checkOutput({e.name, ".y4"}, {7'd0, y4}, {7'd0, e.y4});
            checkOutput({e.name, ".y8"}, {7'd0, y8}, {7'd0, e.y8});
            if (e.chk_w) begin
               checkOutput({e.name, ".w2"}, w2, e.w2);
               checkOutput({e.name, ".w4"}, w4, e.w4);
               checkOutput({e.name, ".w8"}, w8, e.w8);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] data,
                                input logic en_v, input logic rst_v, input bit imm);
      @(negedge clk);
      if (imm) #3;
      else     #1;
      {s2, s1, s0} = sel;
      dv           = data;
      en           = en_v;
      rst_n        = rst_v;
   endtask

   task automatic expectOut(input string name, input logic e2, input logic e4, input logic e8,
                            input bit chk_w, input logic [7:0] ew2, input logic [7:0] ew4,
                            input logic [7:0] ew8, input bit imm);
      exp_t e;
      e.name  = name;
      e.y2    = e2;
      e.y4    = e4;
      e.y8    = e8;
      e.chk_w = chk_w;
      e.w2    = ew2;
      e.w4    = ew4;
      e.w8    = ew8;
      sb.push_back(e);
      if (imm) begin
         #1;
         ->sample_now;
      end
   endtask

   task automatic runVec(input string name, input logic [2:0] sel, input logic [7:0] data,
                         input logic e2, input logic e4, input logic e8);
      applyStimulus(sel, data, 1'b1, 1'b1, 1'b0);
      expectOut(name, e2, e4, e8, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog expired, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      {s2, s1, s0} = 3'd0;
      dv    = 8'h35;
      repeat (2) @(negedge clk);

`ifdef MUX_OUT_REG_EN
      applyStimulus(3'd2, 8'h35, 1'b0, 1'b0, 1'b1);
      expectOut("rst_async", 0, 0, 0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
      applyStimulus(3'd2, 8'h35, 1'b1, 1'b1, 1'b1);
      expectOut("pre_edge", 0, 0, 0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
      expectOut("load_one_edge", 1, 1, 1, 1'b1, 8'hA0, 8'hA2, 8'hA2, 1'b0);
      applyStimulus(3'd1, 8'h35, 1'b0, 1'b1, 1'b0);
      expectOut("hold_en0", 1, 1, 1, 1'b1, 8'hA0, 8'hA2, 8'hA2, 1'b0);
      applyStimulus(3'd5, 8'h35, 1'b1, 1'b1, 1'b0);
      expectOut("load_idx5", 0, 0, 1, 1'b1, 8'hA1, 8'hA1, 8'hA5, 1'b0);
      applyStimulus(3'd5, 8'h35, 1'b1, 1'b0, 1'b1);
      expectOut("rst_midrun", 0, 0, 0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
`else
      applyStimulus(3'd5, 8'h35, 1'b0, 1'b0, 1'b0);
      expectOut("ctl_ignored", 0, 0, 1, 1'b1, 8'hA1, 8'hA1, 8'hA5, 1'b0);
`endif

      // d0..d7 = 1,0,1,0,1,1,0,0
      runVec("idx8_0", 3'd0, 8'h35, 1, 1, 1);
      runVec("idx8_1", 3'd1, 8'h35, 0, 0, 0);
      runVec("idx8_2", 3'd2, 8'h35, 1, 1, 1);
      runVec("idx8_3", 3'd3, 8'h35, 0, 0, 0);
      runVec("idx8_4", 3'd4, 8'h35, 1, 1, 1);
      applyStimulus(3'd5, 8'h35, 1'b1, 1'b1, 1'b0);
      expectOut("idx8_5", 0, 0, 1, 1'b1, 8'hA1, 8'hA1, 8'hA5, 1'b0);
      runVec("idx8_6", 3'd6, 8'h35, 1, 1, 0);
      runVec("idx8_7", 3'd7, 8'h35, 0, 0, 0);

      // each idx4 value visited with s2 low then high; y4 must not move
      runVec("idx4_0_s2lo", 3'd0, 8'h35, 1, 1, 1);
      runVec("idx4_0_s2hi", 3'd4, 8'h35, 1, 1, 1);
      runVec("idx4_1_s2lo", 3'd1, 8'h35, 0, 0, 0);
      runVec("idx4_1_s2hi", 3'd5, 8'h35, 0, 0, 1);
      runVec("idx4_2_s2lo", 3'd2, 8'h35, 1, 1, 1);
      runVec("idx4_2_s2hi", 3'd6, 8'h35, 1, 1, 0);
      runVec("idx4_3_s2lo", 3'd3, 8'h35, 0, 0, 0);
      runVec("idx4_3_s2hi", 3'd7, 8'h35, 0, 0, 0);

      // d0=0, d1=1; s1/s2 toggled around each s0 value
      runVec("y2_s000", 3'd0, 8'h36, 0, 0, 0);
      runVec("y2_s110", 3'd6, 8'h36, 0, 1, 0);
      runVec("y2_s010", 3'd2, 8'h36, 0, 1, 1);
      runVec("y2_s001", 3'd1, 8'h36, 1, 1, 1);
      runVec("y2_s011", 3'd3, 8'h36, 1, 0, 0);
      runVec("y2_s111", 3'd7, 8'h36, 1, 0, 0);
      runVec("y2_s101", 3'd5, 8'h36, 1, 1, 1);

      @(negedge clk);
      @(negedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
